// File: rtl/fifo_pkg.sv
// Shared definitions for the mixed-clock FIFO get-side drainer: default width,
// drainer state encoding and the saturating counter helper.
package fifo_pkg;

    localparam int N_BITS_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_STALL = 2'b10
    } drain_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_get_drainer_if.sv
// Get-port (FIFO side) and valid/ready stream (downstream side) of the drainer.
// master = the drainer, slave = the FIFO plus the downstream consumer.
interface fifo_get_drainer_if import fifo_pkg::*; #(
    parameter int N_BITS = N_BITS_DEF
) ();

    logic              empty_in;
    logic [N_BITS-1:0] data_in;
    logic              req_get;
    logic [N_BITS-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  empty_in,
        input  data_in,
        output req_get,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        output empty_in,
        output data_in,
        input  req_get,
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/get_skid_buf.sv
// DEPTH-entry circular output buffer: pop writes data_in, a stream handshake
// retires the head; m_data/m_valid are registered and always show the head.
module get_skid_buf import fifo_pkg::*; #(
    parameter  int N_BITS = N_BITS_DEF,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pop,
    input  logic [N_BITS-1:0] wr_data,
    input  logic              m_ready,
    output logic [N_BITS-1:0] m_data,
    output logic              m_valid,
    output logic [CNT_W-1:0]  cnt,
    output logic [CNT_W-1:0]  cnt_next
);

    logic [N_BITS-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [N_BITS-1:0] m_data_r;
    logic              m_valid_r;

    logic              push_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [CNT_W-1:0]  remain_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [N_BITS-1:0] head_nxt_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    assign push_s   = m_valid_r & m_ready;
    assign cnt      = cnt_r;
    assign cnt_next = cnt_next_s;
    assign m_data   = m_data_r;
    assign m_valid  = m_valid_r;

    // Next count, pointers and the word that becomes the head after this edge.
    always_comb begin
        cnt_next_s   = cnt_r + CNT_W'(pop) - CNT_W'(push_s);
        remain_s     = cnt_r - CNT_W'(push_s);
        wr_ptr_nxt_s = pop    ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rd_ptr_nxt_s = push_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        // With nothing left after the retire, the head can only be the word arriving now.
        if (remain_s == {CNT_W{1'b0}}) begin
            if (pop) begin
                head_nxt_s = wr_data;
            end else begin
                head_nxt_s = m_data_r;
            end
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Buffer storage, pointers, occupancy and the registered stream outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {N_BITS{1'b0}};
            end
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            m_data_r  <= {N_BITS{1'b0}};
            m_valid_r <= 1'b0;
        end else begin
            if (pop) begin
                mem_r[wr_ptr_r] <= wr_data;
            end
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            cnt_r     <= cnt_next_s;
            m_valid_r <= (cnt_next_s != {CNT_W{1'b0}});
            m_data_r  <= (cnt_next_s != {CNT_W{1'b0}}) ? head_nxt_s : m_data_r;
        end
    end

endmodule

// File: rtl/fifo_get_drainer.sv
// Get-side consumer of the mixed-clock FIFO: paces req_get, buffers DEPTH words and
// re-presents them on a valid/ready stream. Optional feature macro: FIFO_DRAIN_CNT_EN.
module fifo_get_drainer import fifo_pkg::*; #(
    parameter  int N_BITS = N_BITS_DEF,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    fifo_get_drainer_if.master  bus,
`ifdef FIFO_DRAIN_CNT_EN
    output logic [15:0]         drain_cnt,
`endif
    output logic                busy
);

    drain_state_e     state_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             req_get_s;
    logic             drained_s;
    logic             full_next_s;

    // req_get never depends on m_ready, so a full buffer holds off the FIFO for a cycle.
    assign req_get_s   = reset & ~bus.empty_in & (cnt_s < CNT_W'(DEPTH));
    assign bus.req_get = req_get_s;
    assign busy        = busy_r;
    assign drained_s   = (cnt_next_s == {CNT_W{1'b0}}) & bus.empty_in;
    assign full_next_s = (cnt_next_s == CNT_W'(DEPTH));

    get_skid_buf #(
        .N_BITS (N_BITS),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .pop      (req_get_s),
        .wr_data  (bus.data_in),
        .m_ready  (bus.m_ready),
        .m_data   (bus.m_data),
        .m_valid  (bus.m_valid),
        .cnt      (cnt_s),
        .cnt_next (cnt_next_s)
    );

    // Observability FSM with busy registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (drained_s) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_FETCH;
                        busy_r  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (full_next_s) begin
                        state_r <= S_STALL;
                        busy_r  <= 1'b1;
                    end else if (drained_s) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_FETCH;
                        busy_r  <= 1'b1;
                    end
                end
                S_STALL: begin
                    if (full_next_s) begin
                        state_r <= S_STALL;
                        busy_r  <= 1'b1;
                    end else if (drained_s) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_FETCH;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] drain_cnt_r;

    assign drain_cnt = drain_cnt_r;

    // Saturating count of words taken from the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt_r <= 16'h0000;
        end else if (req_get_s) begin
            drain_cnt_r <= sat_inc16(drain_cnt_r);
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_get_drainer.sv
// Directed, table-driven bench for fifo_get_drainer with a FIFO model and a
// scoreboard for the randomised back-pressure run.
module tb_fifo_get_drainer;
    import fifo_pkg::*;

    localparam int NB    = 32;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] drain_cnt;
`endif

    always #5 clk = ~clk;

    fifo_get_drainer_if #(.N_BITS(NB)) bus ();

    fifo_get_drainer #(.N_BITS(NB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
`ifdef FIFO_DRAIN_CNT_EN
        .drain_cnt (drain_cnt),
`endif
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    logic [NB-1:0] src_q[$];
    logic [NB-1:0] exp_q[$];
    bit force_empty = 1'b0;

    typedef struct {
        int           load_n;
        logic [NB-1:0] load_base;
        logic         rdy;
        logic         exp_req;
        logic         exp_valid;
        logic [NB-1:0] exp_data;
        drain_state_e exp_state;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present FIFO state and m_ready, then let combinational outputs settle.
    task automatic drive(input logic rdy);
        bus.m_ready  = rdy;
        bus.empty_in = force_empty || (src_q.size() == 0);
        bus.data_in  = (src_q.size() != 0) ? src_q[0] : 32'h0;
        #1;
    endtask

    // One clock: a sampled req_get removes the FIFO head into the expected-order queue.
    task automatic step();
        bit rq;
        rq = bus.req_get;
        @(posedge clk);
        if (rq) begin
            if (src_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_on_empty actual=1 expected=0");
            end else begin
                exp_q.push_back(src_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int got;
        int cyc;
        bit tog;

        vt[0]  = '{5, 32'hA0, 1'b1, 1'b1, 1'b0, 32'h00, S_IDLE};
        vt[1]  = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA0, S_FETCH};
        vt[2]  = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA1, S_FETCH};
        vt[3]  = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA2, S_FETCH};
        vt[4]  = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA3, S_FETCH};
        vt[5]  = '{0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA4, S_FETCH};
        vt[6]  = '{0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hA4, S_IDLE};
        vt[7]  = '{4, 32'hB0, 1'b0, 1'b1, 1'b0, 32'hA4, S_IDLE};
        vt[8]  = '{0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hB0, S_FETCH};
        vt[9]  = '{0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hB0, S_STALL};
        vt[10] = '{0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hB0, S_STALL};
        vt[11] = '{0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hB0, S_STALL};
        vt[12] = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB1, S_FETCH};
        vt[13] = '{0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hB2, S_FETCH};
        vt[14] = '{0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hB3, S_FETCH};
        vt[15] = '{0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hB3, S_IDLE};

        // Reset held with a non-empty FIFO and a ready consumer.
        bus.empty_in = 1'b0;
        bus.m_ready  = 1'b1;
        bus.data_in  = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_req_get", bus.req_get, 1'b0);
            check("rst_m_valid", bus.m_valid, 1'b0);
            check("rst_busy",    busy,        1'b0);
            check("rst_m_data",  bus.m_data,  32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_req_get", bus.req_get, 1'b1);
        bus.empty_in = 1'b1;
        #1;
        check("empty_glitch_req_get", bus.req_get, 1'b0);
        step();

        // Table: streaming run then back-pressure with stall and in-order recovery.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < vt[i].load_n; k++) begin
                src_q.push_back(vt[i].load_base + NB'(k));
            end
            drive(vt[i].rdy);
            check($sformatf("v%0d_req_get", i), bus.req_get, vt[i].exp_req);
            check($sformatf("v%0d_m_valid", i), bus.m_valid, vt[i].exp_valid);
            check($sformatf("v%0d_m_data", i),  bus.m_data,  vt[i].exp_data);
            check($sformatf("v%0d_state", i),   32'(dut.state_r), 32'(vt[i].exp_state));
            check($sformatf("v%0d_busy", i),    busy, (vt[i].exp_state != S_IDLE) ? 1'b1 : 1'b0);
            step();
        end
        check("tbl_src_drained", 32'(src_q.size()), 32'd0);

        // Toggling empty_in with random back-pressure against a reference queue.
        exp_q.delete();
        for (int i = 0; i < 1000; i++) begin
            src_q.push_back(32'hC000_0000 + NB'(i));
        end
        got = 0;
        cyc = 0;
        tog = 1'b0;
        while (got < 1000 && cyc < 8000) begin
            force_empty = tog;
            tog = ~tog;
            drive(logic'($urandom_range(0, 1)));
            if (bus.empty_in) begin
                check("sb_no_req_when_empty", bus.req_get, 1'b0);
            end
            checks++;
            if (dut.u_buf.cnt_r > DEPTH) begin
                errors++;
                $display("FAIL sb_cnt_bound actual=%0d expected<=%0d", dut.u_buf.cnt_r, DEPTH);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_spurious_word actual=%h expected=none", bus.m_data);
                end else begin
                    check("sb_order", bus.m_data, exp_q.pop_front());
                end
                got++;
            end
            step();
            cyc++;
        end
        check("sb_word_count", 32'(got), 32'd1000);
        force_empty = 1'b0;

        // Async reset with two buffered words discards them and blocks pops.
        src_q.push_back(32'hD0);
        src_q.push_back(32'hD1);
        src_q.push_back(32'hD2);
        drive(1'b0);
        step();
        drive(1'b0);
        step();
        drive(1'b0);
        check("pre_rst_cnt", 32'(dut.u_buf.cnt_r), 32'd2);
        check("pre_rst_req_get", bus.req_get, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_m_valid", bus.m_valid, 1'b0);
        check("async_rst_cnt", 32'(dut.u_buf.cnt_r), 32'd0);
        check("async_rst_req_get", bus.req_get, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1);
            check("in_rst_req_get", bus.req_get, 1'b0);
            step();
        end
        check("in_rst_no_pop", 32'(src_q.size()), 32'd1);
        reset = 1'b1;
        drive(1'b1);
        check("rel_req_get", bus.req_get, 1'b1);
        step();
        drive(1'b1);
        check("rel_m_valid", bus.m_valid, 1'b1);
        check("rel_m_data", bus.m_data, 32'hD2);
        step();
        drive(1'b1);
        check("rel_drained_valid", bus.m_valid, 1'b0);

`ifdef FIFO_DRAIN_CNT_EN
        // Drain counter: clears on reset, counts pops, saturates.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("dc_rst", 32'(drain_cnt), 32'd0);
        bus.empty_in = 1'b0;
        bus.m_ready  = 1'b1;
        bus.data_in  = 32'h77;
        @(negedge clk);
        reset = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("dc_1000", 32'(drain_cnt), 32'd1000);
        repeat (69000) @(posedge clk);
        @(negedge clk);
        check("dc_sat", 32'(drain_cnt), 32'h0000_FFFF);
        reset = 1'b0;
        #1;
        check("dc_rst_clear", 32'(drain_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
